// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch, decode, execute,
// memory and writeback, with a memory-ready handshake that stalls on slow memory.
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StRtypeEx = 4'd6,
      StRtypeWb = 4'd7,
      StBeqEx   = 4'd8,
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
      StJEx     = 4'd11,
      StBneEx   = 4'd12
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   state_e state_q, state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

   assign state = state_q;

   always_comb begin
      state_d    = StFetch;
      pcen       = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      illegal_op = 1'b0;

      case (state_q)
         StFetch: begin
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcen    = mem_ready;
            state_d = mem_ready ? StDecode : StFetch;
         end
         StDecode: begin
            alusrcb = 2'b11;
            case (op)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StRtypeEx;
               OpBeq:      state_d = StBeqEx;
               OpBne:      state_d = StBneEx;
               OpAddi:     state_d = StAddiEx;
               OpJ:        state_d = StJEx;
               default: begin
                  state_d    = StFetch;
                  illegal_op = 1'b1;
               end
            endcase
         end
         StMemAdr: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            if (op == OpLw)      state_d = StMemRd;
            else if (op == OpSw) state_d = StMemWr;
            else                 state_d = StFetch;
         end
         StMemRd: begin
            iord    = 1'b1;
            state_d = mem_ready ? StMemWb : StMemRd;
         end
         StMemWb: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         StMemWr: begin
            iord     = 1'b1;
            memwrite = 1'b1;
            state_d  = mem_ready ? StFetch : StMemWr;
         end
         StRtypeEx: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            state_d = StRtypeWb;
         end
         StRtypeWb: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         StBeqEx: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            pcen    = zero;
         end
         StBneEx: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            pcen    = ~zero;
         end
         StAddiEx: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = StAddiWb;
         end
         StAddiWb: begin
            regwrite = 1'b1;
         end
         StJEx: begin
            pcsrc = 2'b10;
            pcen  = 1'b1;
         end
         default: state_d = StFetch;
      endcase

      // Reset already forces FETCH selects; also kill every enable asynchronously.
      if (reset) begin
         pcen       = 1'b0;
         irwrite    = 1'b0;
         regwrite   = 1'b0;
         memwrite   = 1'b0;
         illegal_op = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl with hand-computed expectations.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic       illegal_op;
   logic [3:0] state;

   int n_vec = 0;
   int n_err = 0;
   int wr_cycles;

   mips_multicycle_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pcen       (pcen),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .aluop      (aluop),
      .pcsrc      (pcsrc),
      .illegal_op (illegal_op),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      op        = 6'b000000;
      zero      = 1'b0;
      mem_ready = 1'b1;
      #12;
      check("rst_state", state, 0);
      check("rst_pcen", pcen, 0);
      check("rst_irwrite", irwrite, 0);
      check("rst_alusrcb", alusrcb, 2'b01);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("fetch0_irwrite", irwrite, 1);
      check("fetch0_pcen", pcen, 1);

      // lw: 0,1,2,3,4,0
      op = 6'b100011;
      tick(); check("lw_s1", state, 1); check("lw_dec_alusrcb", alusrcb, 2'b11);
      tick(); check("lw_s2", state, 2); check("lw_adr_alusrcb", alusrcb, 2'b10);
      tick(); check("lw_s3", state, 3); check("lw_rd_iord", iord, 1);
      tick(); check("lw_s4", state, 4);
      check("lw_wb_regwrite", regwrite, 1);
      check("lw_wb_memtoreg", memtoreg, 1);
      check("lw_wb_regdst", regdst, 0);
      tick(); check("lw_s0", state, 0);

      // R-type: 0,1,6,7,0
      op = 6'b000000;
      tick(); check("rt_s1", state, 1);
      tick(); check("rt_s6", state, 6); check("rt_aluop", aluop, 2'b10);
      tick(); check("rt_s7", state, 7); check("rt_regdst", regdst, 1);
      check("rt_regwrite", regwrite, 1);
      tick(); check("rt_s0", state, 0);

      // reset mid-RTYPEWB
      tick(); tick(); tick();
      check("rr_s7", state, 7);
      reset = 1'b1;
      #1;
      check("rr_regwrite", regwrite, 0);
      check("rr_state", state, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rr_irwrite", irwrite, 1);
      check("rr_pcen", pcen, 1);

      // sw with 3 stall cycles in MEMWR
      op = 6'b101011;
      tick(); check("sw_s1", state, 1);
      tick(); check("sw_s2", state, 2);
      mem_ready = 1'b0;
      wr_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) begin
            mem_ready = 1'b1;
            #1;
         end
         check("sw_s5", state, 5);
         check("sw_regwrite", regwrite, 0);
         if (memwrite) wr_cycles++;
      end
      tick(); check("sw_s0", state, 0); check("sw_memwrite_off", memwrite, 0);
      check("sw_wr_cycles", wr_cycles, 4);

      // FETCH stall
      mem_ready = 1'b0;
      #1;
      check("fs_irwrite0", irwrite, 0); check("fs_pcen0", pcen, 0);
      tick(); check("fs_state", state, 0); check("fs_irwrite1", irwrite, 0);
      tick();
      mem_ready = 1'b1;
      #1;
      check("fs_irwrite_rdy", irwrite, 1); check("fs_pcen_rdy", pcen, 1);

      // beq, zero toggled within BEQEX
      op = 6'b000100;
      tick(); check("beq_s1", state, 1);
      tick(); check("beq_s8", state, 8);
      zero = 1'b1; #1;
      check("beq_z1_pcen", pcen, 1); check("beq_pcsrc", pcsrc, 2'b01);
      check("beq_aluop", aluop, 2'b01);
      zero = 1'b0; #1;
      check("beq_z0_pcen", pcen, 0);
      tick(); check("beq_s0", state, 0);

      // bne
      op = 6'b000101;
      tick(); check("bne_s1", state, 1);
      tick(); check("bne_s12", state, 12);
      zero = 1'b1; #1;
      check("bne_z1_pcen", pcen, 0);
      zero = 1'b0; #1;
      check("bne_z0_pcen", pcen, 1); check("bne_pcsrc", pcsrc, 2'b01);
      tick(); check("bne_s0", state, 0);

      // j: 0,1,11,0
      op = 6'b000010;
      tick(); check("j_s1", state, 1);
      tick(); check("j_s11", state, 11);
      check("j_pcsrc", pcsrc, 2'b10); check("j_pcen", pcen, 1);
      tick(); check("j_s0", state, 0);

      // addi: 0,1,9,10,0
      op = 6'b001000;
      tick(); check("addi_s1", state, 1);
      tick(); check("addi_s9", state, 9); check("addi_alusrcb", alusrcb, 2'b10);
      tick(); check("addi_s10", state, 10); check("addi_regwrite", regwrite, 1);
      check("addi_memtoreg", memtoreg, 0);
      tick(); check("addi_s0", state, 0);

      // illegal opcode
      op = 6'b111111;
      tick(); check("ill_s1", state, 1); check("ill_flag", illegal_op, 1);
      check("ill_regwrite", regwrite, 0); check("ill_memwrite", memwrite, 0);
      tick(); check("ill_s0", state, 0); check("ill_flag_clr", illegal_op, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS core. It decodes the opcode held in the instruction register and sequences the shared datapath through fetch, decode, execute, memory and writeback: PC, instruction/data memory port, register file, ALU source muxes, and branch/jump target selection (offset and jump field shifted left by two). A memory-ready handshake lets the FSM stall on slow memory. It sits between the instruction register and the datapath mux/enable inputs; the ALU decoder consumes `aluop`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `op`  in  6  opcode, `instr[31:26]`, from the instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `pcen`  out  1  PC load enable.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  instruction register load.
- `regdst`  out  1  destination register: 0 = rt, 1 = rd.
- `memtoreg`  out  1  writeback data: 0 = ALUOut, 1 = data register.
- `regwrite`  out  1  register file write.
- `alusrca`  out  1  ALU A: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `aluop`  out  2  00 = add, 01 = subtract, 10 = use funct.
- `pcsrc`  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `state`  out  4  current state encoding, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12.
- Unlisted outputs are 0 in each state.

State behaviour:
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=pcen=mem_ready. Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (computes branch target PC+4+(SignImm<<2) into ALUOut). Next state by op:
  - lw or sw: MEMADR.
  - R-type: RTYPEEX.
  - beq: BEQEX.
  - bne: BNEEX.
  - addi: ADDIEX.
  - j: JEX.
  - Any other op: FETCH, with illegal_op=1 for that cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Waits for mem_ready, then goes to MEMWB. The data register captures every cycle, so the data present on the mem_ready cycle is what MEMWB writes.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR: iord=1, memwrite=1. memwrite is held until mem_ready, then goes to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Goes to RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero. Goes to FETCH.
- BNEEX: as BEQEX but pcen=!zero. Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
- JEX: pcsrc=10, pcen=1. Goes to FETCH.
- Encodings 13–15 are unreachable. If entered, all write enables are 0 and the next state is FETCH.

Output structure:
- Outputs are decoded combinationally from the registered state (Moore).
- Exceptions: pcen depends on zero (branch states) or mem_ready (FETCH); irwrite depends on mem_ready.

## Timing
- State register updates on the rising edge of clk. reset forces FETCH immediately and asynchronously.
- While reset=1: pcen, irwrite, regwrite, memwrite and illegal_op are forced to 0, and the mux selects hold their FETCH values. state reads 0.
- The first fetch begins on the first rising edge after reset deasserts.
- Cycles per instruction with mem_ready constantly high, counted from entry to FETCH:
  - lw 5.
  - sw 4, R-type 4, addi 4.
  - beq 3, bne 3, j 3, illegal 2.
- Each cycle with mem_ready low in FETCH, MEMRD or MEMWR adds exactly one cycle. No write enable is asserted during a stall, except memwrite held in MEMWR.
- op is sampled only in DECODE and MEMADR. The IR is stable then, because irwrite is only asserted in FETCH.
- reset asserted mid-instruction, including during a MEMWR stall, drops memwrite and regwrite combinationally and returns to FETCH. No partial writeback occurs.

## Test plan
- Reset: assert reset mid-RTYPEWB -> regwrite=0 at once, state=0; after release with mem_ready=1, irwrite=pcen=1 in the first cycle.
- lw (op=100011), mem_ready=1 -> state sequence 0,1,2,3,4,0. In MEMWB: regwrite=1, memtoreg=1, regdst=0. alusrcb=11 in DECODE.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for exactly 4 cycles, then FETCH. regwrite never asserted.
- beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX. beq with zero=0 -> pcen=0. bne inverts both cases.
- j (op=000010) -> state sequence 0,1,11,0, with pcsrc=10 and pcen=1 in JEX. R-type -> 0,1,6,7,0, with aluop=10 in state 6 and regdst=1 in state 7.
- Illegal op=111111 -> DECODE raises illegal_op for one cycle, next state is 0, and no regwrite or memwrite occurs. FETCH stall: mem_ready=0 for 2 cycles -> irwrite=pcen=0 until the ready cycle.
